// File: rtl/regfile_sb.sv
// Scoreboarded 32x32 register file: per-register pending-writer counts gate
// combinational operand reads, with ex/mem/wb forwarding for in-flight values.
module regfile_sb (
    input  logic        clk,
    input  logic        rst,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    output logic        suc1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic        suc2,
    input  logic        issue_v,
    input  logic        issue_we,
    input  logic [4:0]  issue_wd,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_wd,
    input  logic        ex_rdy,
    input  logic [31:0] ex_wdata,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_wd,
    input  logic [31:0] mem_wdata,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic        err
);

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 2;

    logic [DW-1:0] regs_q [NREG];
    logic [CW-1:0] cnt_q  [NREG];
    logic [CW-1:0] cnt_d  [NREG];
    logic          err_q;
    logic          err_d;
    logic          inc;
    logic          dec;
    logic [DW:0]   rd1;
    logic [DW:0]   rd2;

    assign inc = issue_v & issue_we & (issue_wd != AW'(0));
    assign dec = we & (waddr != AW'(0));

    // Pending-count update; a simultaneous inc/dec of one register cancels out.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (!(inc && dec && (issue_wd == waddr))) begin
            if (inc) begin
                if (cnt_q[issue_wd] == CW'(3)) err_d = 1'b1;
                else cnt_d[issue_wd] = CW'(cnt_q[issue_wd] + CW'(1));
            end
            if (dec) begin
                if (cnt_q[waddr] == CW'(0)) err_d = 1'b1;
                else cnt_d[waddr] = CW'(cnt_q[waddr] - CW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (dec) regs_q[waddr] <= wdata;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Returns {suc, rdata}; the youngest in-flight producer wins.
    function automatic logic [DW:0] rd_port(
        input logic          re_en,
        input logic [AW-1:0] ra,
        input logic [CW-1:0] cnt,
        input logic [DW-1:0] rv,
        input logic          rst_en,
        input logic          exw,
        input logic [AW-1:0] exd,
        input logic          exr,
        input logic [DW-1:0] exv,
        input logic          memw,
        input logic [AW-1:0] memd,
        input logic [DW-1:0] memv,
        input logic          wbw,
        input logic [AW-1:0] wbd,
        input logic [DW-1:0] wbv
    );
        logic [DW:0] r;
        r = '0;
        if (rst_en || !re_en || (ra == AW'(0)))   r = {1'b1, DW'(0)};
        else if (cnt == CW'(0))                   r = {1'b1, rv};
        else if (exw && (exd == ra))              r = {exr, exr ? exv : DW'(0)};
        else if (memw && (memd == ra))            r = {1'b1, memv};
        else if (wbw && (wbd == ra) && (cnt == CW'(1))) r = {1'b1, wbv};
        else                                      r = '0;
        return r;
    endfunction

    always_comb begin
        rd1 = rd_port(re1, raddr1, cnt_q[raddr1], regs_q[raddr1], rst,
                      ex_wreg, ex_wd, ex_rdy, ex_wdata, mem_wreg, mem_wd, mem_wdata,
                      we, waddr, wdata);
        rd2 = rd_port(re2, raddr2, cnt_q[raddr2], regs_q[raddr2], rst,
                      ex_wreg, ex_wd, ex_rdy, ex_wdata, mem_wreg, mem_wd, mem_wdata,
                      we, waddr, wdata);
    end

    assign rdata1 = rd1[DW-1:0];
    assign suc1   = rd1[DW];
    assign rdata2 = rd2[DW-1:0];
    assign suc2   = rd2[DW];
    assign err    = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: forwarding priority, pending counts, err, reset.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        suc1, suc2;
    logic        issue_v, issue_we;
    logic [4:0]  issue_wd;
    logic        ex_wreg, ex_rdy;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .suc1(suc1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .suc2(suc2),
        .issue_v(issue_v), .issue_we(issue_we), .issue_wd(issue_wd),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_rdy(ex_rdy), .ex_wdata(ex_wdata),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        issue_v = 0; issue_we = 0; issue_wd = 0;
        ex_wreg = 0; ex_wd = 0; ex_rdy = 0; ex_wdata = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
        we = 0; waddr = 0; wdata = 0;
    endtask

    task automatic iss(input logic [4:0] r);
        issue_v = 1; issue_we = 1; issue_wd = r;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        we = 1; waddr = r; wdata = d;
    endtask

    task automatic rd1(input logic [4:0] r);
        re1 = 1; raddr1 = r;
    endtask

    task automatic rd2(input logic [4:0] r);
        re2 = 1; raddr2 = r;
    endtask

    initial begin
        // Reset cycle: outputs forced, issue/writeback discarded
        clr(); rst = 1;
        rd1(5); rd2(5); iss(5); wb(5, 32'hDEAD);
        #1;
        check("rst_rdata1", rdata1, 0);
        check("rst_suc1",   32'(suc1), 1);
        check("rst_suc2",   32'(suc2), 1);
        tick();
        rst = 0; clr(); rd1(5); #1;
        check("post_rst_rdata1", rdata1, 0);
        check("post_rst_suc1",   32'(suc1), 1);
        check("post_rst_err",    32'(err), 0);
        tick();

        // Write then read
        clr(); iss(5); tick();
        clr(); wb(5, 32'h1234); rd1(5); #1;
        check("wb_fwd_rdata1", rdata1, 32'h1234);
        check("wb_fwd_suc1",   32'(suc1), 1);
        tick();
        clr(); rd1(5); #1;
        check("wr_rd_rdata1", rdata1, 32'h1234);
        check("wr_rd_suc1",   32'(suc1), 1);
        check("wr_rd_err",    32'(err), 0);
        tick();

        // Load-use hazard on x7; same-cycle read sees pre-issue count
        clr(); iss(7); rd2(7); #1;
        check("issue_self_suc2", 32'(suc2), 1);
        tick();
        clr(); ex_wreg = 1; ex_wd = 7; ex_rdy = 0; rd2(7); #1;
        check("load_use_suc2",   32'(suc2), 0);
        check("load_use_rdata2", rdata2, 0);
        tick();
        clr(); mem_wreg = 1; mem_wd = 7; mem_wdata = 32'hAB; rd2(7); #1;
        check("mem_fwd_rdata2", rdata2, 32'hAB);
        check("mem_fwd_suc2",   32'(suc2), 1);
        tick();
        clr(); wb(7, 32'hAB); tick();

        // ex > mem priority, two pending writers on x3
        clr(); iss(3); tick();
        clr(); iss(3); tick();
        clr(); ex_wreg = 1; ex_wd = 3; ex_rdy = 1; ex_wdata = 32'h11;
        mem_wreg = 1; mem_wd = 3; mem_wdata = 32'h22; rd1(3); #1;
        check("prio_rdata1", rdata1, 32'h11);
        check("prio_suc1",   32'(suc1), 1);
        ex_rdy = 0; #1;
        check("prio_notrdy_suc1",   32'(suc1), 0);
        check("prio_notrdy_rdata1", rdata1, 0);
        clr(); wb(3, 32'h22); rd1(3); #1;
        check("two_pend_suc1",   32'(suc1), 0);
        check("two_pend_rdata1", rdata1, 0);
        tick();
        clr(); wb(3, 32'h11); rd1(3); #1;
        check("one_pend_wb_rdata1", rdata1, 32'h11);
        check("one_pend_wb_suc1",   32'(suc1), 1);
        tick();
        clr(); rd1(3); #1;
        check("x3_final_rdata1", rdata1, 32'h11);

        // Simultaneous issue+writeback on x9 keeps cnt at 1
        clr(); iss(9); tick();
        clr(); iss(9); wb(9, 32'h99); tick();
        clr(); rd1(9); #1;
        check("x9_pend_suc1", 32'(suc1), 0);
        clr(); wb(9, 32'h77); iss(10); rd1(9); #1;
        check("x9_wb_rdata1", rdata1, 32'h77);
        check("x9_wb_suc1",   32'(suc1), 1);
        tick();
        clr(); rd1(9); rd2(10); #1;
        check("x9_clear_rdata1", rdata1, 32'h77);
        check("x9_clear_suc1",   32'(suc1), 1);
        check("x10_pend_suc2",   32'(suc2), 0);

        // x0 never pends, never written, never errs
        clr(); iss(0); wb(0, 32'hFFFF); rd1(0); #1;
        check("x0_rdata1", rdata1, 0);
        check("x0_suc1",   32'(suc1), 1);
        tick();
        clr(); rd1(0); #1;
        check("x0_after_rdata1", rdata1, 0);
        check("x0_after_suc1",   32'(suc1), 1);
        check("x0_err",          32'(err), 0);

        // Pending read on x12 until ex delivers
        clr(); iss(12); tick();
        clr(); rd1(12); #1;
        check("x12_pend_suc1",   32'(suc1), 0);
        check("x12_pend_rdata1", rdata1, 0);
        tick(); #1;
        check("x12_pend2_suc1", 32'(suc1), 0);
        re1 = 0; #1;
        check("re0_suc1",   32'(suc1), 1);
        check("re0_rdata1", rdata1, 0);
        re1 = 1; ex_wreg = 1; ex_wd = 12; ex_rdy = 1; ex_wdata = 32'h5A5A; #1;
        check("x12_ex_rdata1", rdata1, 32'h5A5A);
        check("x12_ex_suc1",   32'(suc1), 1);
        tick();

        // Counter saturation on x4
        for (int i = 0; i < 3; i++) begin
            clr(); iss(4); tick();
        end
        check("x4_cnt3_err", 32'(err), 0);
        clr(); iss(4); tick();
        check("x4_ovf_err", 32'(err), 1);
        clr(); wb(4, 32'h44); rd1(4); #1;
        check("x4_cnt3_suc1", 32'(suc1), 0);
        tick();
        clr(); wb(4, 32'h44); tick();
        clr(); wb(4, 32'h45); rd1(4); #1;
        check("x4_cnt1_rdata1", rdata1, 32'h45);
        check("x4_cnt1_suc1",   32'(suc1), 1);
        tick();
        clr(); iss(4); tick();
        check("err_sticky", 32'(err), 1);

        // Mid-operation reset
        clr(); rst = 1; rd1(4); #1;
        check("rst2_rdata1", rdata1, 0);
        check("rst2_suc1",   32'(suc1), 1);
        tick();
        rst = 0; clr(); rd1(4); rd2(10); #1;
        check("rst2_err",    32'(err), 0);
        check("x4_rst_rdata1", rdata1, 0);
        check("x4_rst_suc1",   32'(suc1), 1);
        check("x10_rst_suc2",  32'(suc2), 1);

        // Underflow: writeback with nothing pending
        clr(); wb(6, 32'h66); tick();
        clr(); rd1(6); #1;
        check("unf_err",    32'(err), 1);
        check("unf_rdata1", rdata1, 32'h66);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
